// File: rtl/ezrisc_pkg.sv
// Shared definitions for the ezrisc datapath: ALU function codes, IR field
// positions and the default RAM depth.
package ezrisc_pkg;

  localparam int MEM_DEPTH = 512;

  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C_MSB  = 18;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_MUL = 4'd8,
    ALU_DIV = 4'd9,
    ALU_NEG = 4'd10,
    ALU_NOT = 4'd11
  } alu_op_e;

endpackage

// File: rtl/ezrisc_reg32.sv
// 32-bit load-enabled register with asynchronous active-low clear; every
// 32-bit register of the datapath is one of these.
module reg32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ezrisc_datapath.sv
// Single-bus 32-bit CPU datapath sequenced by an external control unit.
// RAM contents start zeroed.
module ezrisc_datapath #(
  parameter int MEM_DEPTH     = ezrisc_pkg::MEM_DEPTH,
  parameter     MEM_INIT_FILE = "mem.hex"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        r_in,
  input  logic        r_out,
  input  logic        ba_out,
  input  logic        hi_in,
  input  logic        lo_in,
  input  logic        pc_in,
  input  logic        ir_in,
  input  logic        y_in,
  input  logic        mar_in,
  input  logic        mdr_in,
  input  logic        z_in,
  input  logic        outport_in,
  input  logic        hi_out,
  input  logic        lo_out,
  input  logic        pc_out,
  input  logic        mdr_out,
  input  logic        z_high_out,
  input  logic        z_low_out,
  input  logic        inport_out,
  input  logic        c_out,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  alu_op,
  input  logic        inc_pc,
  input  logic [31:0] inport_ext_input,
  output logic [31:0] bus_data,
  output logic [31:0] outport_ext_output
);

  import ezrisc_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);

  logic [3:0]  gpr_idx;
  logic [15:0] gpr_en;
  logic [31:0] gpr_q [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q, y_q, mdr_q, in_q, zhi_q, zlo_q;
  logic [AW-1:0] mar_q;
  logic [31:0] c_val, mdr_d, ram_rd;
  logic [63:0] alu_res, z_d, rot;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;
  logic [31:0] mem [MEM_DEPTH];
  logic        unused_ir;

  assign unused_ir = ^ir_q[31:27];

  // Register index: OR of whichever IR fields the control unit gates in.
  assign gpr_idx = ({4{gra}} & ir_q[IR_RA_MSB:IR_RA_LSB])
                 | ({4{grb}} & ir_q[IR_RB_MSB:IR_RB_LSB])
                 | ({4{grc}} & ir_q[IR_RC_MSB:IR_RC_LSB]);

  assign c_val = {{(31-IR_C_MSB){ir_q[IR_C_MSB]}}, ir_q[IR_C_MSB:0]};

  always_comb begin
    gpr_en = '0;
    if (r_in) gpr_en[gpr_idx] = 1'b1;
  end

  reg32 r0  (.clk(clk), .reset_n(reset_n), .en(gpr_en[0]),  .d(bus_data), .q(gpr_q[0]));
  reg32 r1  (.clk(clk), .reset_n(reset_n), .en(gpr_en[1]),  .d(bus_data), .q(gpr_q[1]));
  reg32 r2  (.clk(clk), .reset_n(reset_n), .en(gpr_en[2]),  .d(bus_data), .q(gpr_q[2]));
  reg32 r3  (.clk(clk), .reset_n(reset_n), .en(gpr_en[3]),  .d(bus_data), .q(gpr_q[3]));
  reg32 r4  (.clk(clk), .reset_n(reset_n), .en(gpr_en[4]),  .d(bus_data), .q(gpr_q[4]));
  reg32 r5  (.clk(clk), .reset_n(reset_n), .en(gpr_en[5]),  .d(bus_data), .q(gpr_q[5]));
  reg32 r6  (.clk(clk), .reset_n(reset_n), .en(gpr_en[6]),  .d(bus_data), .q(gpr_q[6]));
  reg32 r7  (.clk(clk), .reset_n(reset_n), .en(gpr_en[7]),  .d(bus_data), .q(gpr_q[7]));
  reg32 r8  (.clk(clk), .reset_n(reset_n), .en(gpr_en[8]),  .d(bus_data), .q(gpr_q[8]));
  reg32 r9  (.clk(clk), .reset_n(reset_n), .en(gpr_en[9]),  .d(bus_data), .q(gpr_q[9]));
  reg32 r10 (.clk(clk), .reset_n(reset_n), .en(gpr_en[10]), .d(bus_data), .q(gpr_q[10]));
  reg32 r11 (.clk(clk), .reset_n(reset_n), .en(gpr_en[11]), .d(bus_data), .q(gpr_q[11]));
  reg32 r12 (.clk(clk), .reset_n(reset_n), .en(gpr_en[12]), .d(bus_data), .q(gpr_q[12]));
  reg32 r13 (.clk(clk), .reset_n(reset_n), .en(gpr_en[13]), .d(bus_data), .q(gpr_q[13]));
  reg32 r14 (.clk(clk), .reset_n(reset_n), .en(gpr_en[14]), .d(bus_data), .q(gpr_q[14]));
  reg32 r15 (.clk(clk), .reset_n(reset_n), .en(gpr_en[15]), .d(bus_data), .q(gpr_q[15]));

  reg32 hi_reg  (.clk(clk), .reset_n(reset_n), .en(hi_in),      .d(bus_data),         .q(hi_q));
  reg32 lo_reg  (.clk(clk), .reset_n(reset_n), .en(lo_in),      .d(bus_data),         .q(lo_q));
  reg32 pc_reg  (.clk(clk), .reset_n(reset_n), .en(pc_in),      .d(bus_data),         .q(pc_q));
  reg32 ir_reg  (.clk(clk), .reset_n(reset_n), .en(ir_in),      .d(bus_data),         .q(ir_q));
  reg32 y_reg   (.clk(clk), .reset_n(reset_n), .en(y_in),       .d(bus_data),         .q(y_q));
  reg32 mdr_reg (.clk(clk), .reset_n(reset_n), .en(mdr_in),     .d(mdr_d),            .q(mdr_q));
  reg32 in_reg  (.clk(clk), .reset_n(reset_n), .en(1'b1),       .d(inport_ext_input), .q(in_q));
  reg32 out_reg (.clk(clk), .reset_n(reset_n), .en(outport_in), .d(bus_data),         .q(outport_ext_output));
  reg32 zhi_reg (.clk(clk), .reset_n(reset_n), .en(z_in),       .d(z_d[63:32]),       .q(zhi_q));
  reg32 zlo_reg (.clk(clk), .reset_n(reset_n), .en(z_in),       .d(z_d[31:0]),        .q(zlo_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mar_q <= '0;
    else if (mar_in) mar_q <= bus_data[AW-1:0];
  end

  // Bus source priority: GPR, HI, LO, Zhi, Zlo, PC, MDR, IN, C.
  always_comb begin
    bus_data = '0;
    if (r_out)           bus_data = gpr_q[gpr_idx];
    else if (ba_out)     bus_data = (gpr_idx == 4'd0) ? 32'd0 : gpr_q[gpr_idx];
    else if (hi_out)     bus_data = hi_q;
    else if (lo_out)     bus_data = lo_q;
    else if (z_high_out) bus_data = zhi_q;
    else if (z_low_out)  bus_data = zlo_q;
    else if (pc_out)     bus_data = pc_q;
    else if (mdr_out)    bus_data = mdr_q;
    else if (inport_out) bus_data = in_q;
    else if (c_out)      bus_data = c_val;
  end

  assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus_data[31]}}, bus_data});
  assign quo  = $signed(y_q) / $signed(bus_data);
  assign rem  = $signed(y_q) % $signed(bus_data);

  always_comb begin
    alu_res = '0;
    rot     = '0;
    case (alu_op_e'(alu_op))
      ALU_AND: alu_res = {32'd0, y_q & bus_data};
      ALU_OR:  alu_res = {32'd0, y_q | bus_data};
      ALU_ADD: alu_res = {32'd0, y_q + bus_data};
      ALU_SUB: alu_res = {32'd0, y_q - bus_data};
      ALU_SHR: alu_res = {32'd0, y_q >> bus_data[4:0]};
      ALU_SHL: alu_res = {32'd0, y_q << bus_data[4:0]};
      ALU_ROR: begin
        rot     = {y_q, y_q} >> bus_data[4:0];
        alu_res = {32'd0, rot[31:0]};
      end
      ALU_ROL: begin
        rot     = {y_q, y_q} << bus_data[4:0];
        alu_res = {32'd0, rot[63:32]};
      end
      ALU_MUL: alu_res = prod;
      ALU_DIV: if (bus_data != 32'd0) alu_res = {rem, quo};
      ALU_NEG: alu_res = {32'd0, 32'd0 - bus_data};
      ALU_NOT: alu_res = {32'd0, ~bus_data};
      default: alu_res = '0;
    endcase
  end

  assign z_d = inc_pc ? {32'd0, bus_data + 32'd1} : alu_res;

  // RAM: combinational read; a same-edge read+write hands MDR the old word.
  assign ram_rd = mem[mar_q];
  assign mdr_d  = read ? ram_rd : bus_data;

  localparam int unused_init_file_bits = $bits(MEM_INIT_FILE);
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (write) mem[mar_q] <= mdr_q;
  end

endmodule

// File: tb/tb_ezrisc_datapath.sv
// Self-checking bench for ezrisc_datapath: bus-driven transfers, fetch,
// ALU table plus random ops, memory and asynchronous reset, all via a scoreboard.
module tb_ezrisc_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        gra, grb, grc, r_in, r_out, ba_out;
  logic        hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in, z_in, outport_in;
  logic        hi_out, lo_out, pc_out, mdr_out, z_high_out, z_low_out, inport_out, c_out;
  logic        read, write, inc_pc;
  logic [3:0]  alu_op;
  logic [31:0] inport_ext_input;
  logic [31:0] bus_data;
  logic [31:0] outport_ext_output;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  ezrisc_datapath dut (
    .clk(clk), .reset_n(reset_n),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .z_in(z_in), .outport_in(outport_in),
    .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out), .mdr_out(mdr_out),
    .z_high_out(z_high_out), .z_low_out(z_low_out), .inport_out(inport_out), .c_out(c_out),
    .read(read), .write(write), .alu_op(alu_op), .inc_pc(inc_pc),
    .inport_ext_input(inport_ext_input),
    .bus_data(bus_data), .outport_ext_output(outport_ext_output)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic observe(input string tag, input logic [63:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      check(tag, act, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic clear_ctrl();
    {gra, grb, grc, r_in, r_out, ba_out} = '0;
    {hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in, z_in, outport_in} = '0;
    {hi_out, lo_out, pc_out, mdr_out, z_high_out, z_low_out, inport_out, c_out} = '0;
    {read, write, inc_pc} = '0;
    alu_op = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clear_ctrl();
  endtask

  // Leaves the bus driven by IN = v; caller adds the load enable and ticks.
  task automatic drive_in(input logic [31:0] v);
    inport_ext_input = v;
    tick();
    inport_out = 1'b1;
  endtask

  task automatic sample_bus(input string tag, input logic [31:0] exp);
    expect_v({32'd0, exp});
    #1;
    observe(tag, {32'd0, bus_data});
    clear_ctrl();
  endtask

  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic signed [63:0] sa, sb;
    r = a;
    case (op)
      4'd0: return {32'd0, a & b};
      4'd1: return {32'd0, a | b};
      4'd2: return {32'd0, a + b};
      4'd3: return {32'd0, a + ~b + 32'd1};
      4'd4: begin for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; return {32'd0, r}; end
      4'd5: begin for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; return {32'd0, r}; end
      4'd6: begin for (int i = 0; i < int'(b[4:0]); i++) r = {r[0], r[31:1]}; return {32'd0, r}; end
      4'd7: begin for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], r[31]}; return {32'd0, r}; end
      4'd8: begin sa = signed'({{32{a[31]}}, a}); sb = signed'({{32{b[31]}}, b}); return sa * sb; end
      4'd9: begin
        if (b == 32'd0) return 64'd0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      4'd10: return {32'd0, ~b + 32'd1};
      4'd11: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic alu_case(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    drive_in(a);
    y_in = 1'b1;
    tick();
    drive_in(b);
    alu_op = op;
    z_in = 1'b1;
    r = alu_model(op, a, b);
    expect_v({32'd0, r[63:32]});
    expect_v({32'd0, r[31:0]});
    tick();
    z_high_out = 1'b1;
    #1 observe($sformatf("alu%0d_zhi a=%h b=%h", op, a, b), {32'd0, bus_data});
    z_high_out = 1'b0;
    z_low_out = 1'b1;
    #1 observe($sformatf("alu%0d_zlo a=%h b=%h", op, a, b), {32'd0, bus_data});
    clear_ctrl();
  endtask

  // stimulus
  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    reset_n = 1'b0;
    inport_ext_input = 32'd0;
    clear_ctrl();
    #2;
    expect_v(64'd0);
    observe("reset_outport", {32'd0, outport_ext_output});
    sample_bus("reset_bus_idle", 32'd0);
    pc_out = 1'b1;
    sample_bus("reset_pc", 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAM[0] <= 0xB0800000 through MAR/MDR
    drive_in(32'd0);            mar_in = 1'b1; tick();
    drive_in(32'hB080_0000);    mdr_in = 1'b1; tick();
    write = 1'b1; tick();

    // fetch
    pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; tick();
    z_low_out = 1'b1;  sample_bus("t0_zlo", 32'd1);
    z_high_out = 1'b1; sample_bus("t0_zhi", 32'd0);
    z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; tick();
    pc_out = 1'b1;  sample_bus("t1_pc", 32'd1);
    mdr_out = 1'b1; sample_bus("t1_mdr", 32'hB080_0000);
    mdr_out = 1'b1; ir_in = 1'b1; tick();
    c_out = 1'b1;   sample_bus("t2_c", 32'd0);

    // out instruction, ra = 1
    drive_in(32'h1F); gra = 1'b1; r_in = 1'b1; tick();
    gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; tick();
    expect_v(64'h1F);
    observe("t3_outport", {32'd0, outport_ext_output});
    gra = 1'b1; r_out = 1'b1; sample_bus("r1_bus", 32'h1F);

    // C sign extension
    drive_in(32'h0004_0005); ir_in = 1'b1; tick();
    c_out = 1'b1; sample_bus("c_neg", 32'hFFFC_0005);
    drive_in(32'h0001_2345); ir_in = 1'b1; tick();
    c_out = 1'b1; sample_bus("c_pos", 32'h0001_2345);

    // rc field selects R1
    drive_in(32'h0000_8000); ir_in = 1'b1; tick();
    grc = 1'b1; r_out = 1'b1; sample_bus("grc_r1", 32'h1F);

    // R0 with ba_out / r_out
    drive_in(32'd0); ir_in = 1'b1; tick();
    drive_in(32'h55); gra = 1'b1; r_in = 1'b1; tick();
    gra = 1'b1; ba_out = 1'b1; sample_bus("ba_out_r0", 32'd0);
    gra = 1'b1; r_out = 1'b1;  sample_bus("r_out_r0", 32'h55);

    // HI/LO and bus priority
    drive_in(32'hAAAA_0001); hi_in = 1'b1; tick();
    drive_in(32'h5555_0002); lo_in = 1'b1; tick();
    hi_out = 1'b1; sample_bus("hi", 32'hAAAA_0001);
    lo_out = 1'b1; sample_bus("lo", 32'h5555_0002);
    gra = 1'b1; r_out = 1'b1; hi_out = 1'b1; sample_bus("prio_gpr_hi", 32'h55);
    hi_out = 1'b1; lo_out = 1'b1; pc_out = 1'b1; sample_bus("prio_hi_lo", 32'hAAAA_0001);
    lo_out = 1'b1; mdr_out = 1'b1; sample_bus("prio_lo_mdr", 32'h5555_0002);

    // ALU directed cases
    alu_case(4'd3, 32'd7, 32'd3);
    alu_case(4'd8, 32'hFFFF_FFFE, 32'd3);
    alu_case(4'd9, 32'd7, 32'd3);
    alu_case(4'd9, 32'd7, 32'd0);
    alu_case(4'd9, 32'hFFFF_FFF9, 32'd2);
    alu_case(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    alu_case(4'd1, 32'hF000_0000, 32'h0000_000F);
    alu_case(4'd2, 32'hFFFF_FFFF, 32'd2);
    alu_case(4'd4, 32'h8000_0000, 32'd31);
    alu_case(4'd5, 32'h0000_0003, 32'd30);
    alu_case(4'd6, 32'h0000_0001, 32'd1);
    alu_case(4'd7, 32'h8000_0001, 32'd4);
    alu_case(4'd8, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    alu_case(4'd10, 32'd9, 32'd5);
    alu_case(4'd11, 32'd9, 32'h1234_5678);
    alu_case(4'd12, 32'd9, 32'd5);
    alu_case(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // ALU random cases
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      if (i % 6 == 0) b = 32'd0;
      if (op == 4'd9 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      alu_case(op, a, b);
    end

    // inc_pc wraps and overrides alu_op
    drive_in(32'hFFFF_FFFF); inc_pc = 1'b1; alu_op = 4'd8; z_in = 1'b1; tick();
    z_low_out = 1'b1;  sample_bus("inc_wrap_zlo", 32'd0);
    z_high_out = 1'b1; sample_bus("inc_wrap_zhi", 32'd0);

    // memory write / read-back, then simultaneous read+write
    drive_in(32'd5);           mar_in = 1'b1; tick();
    drive_in(32'hDEAD_BEEF);   mdr_in = 1'b1; tick();
    write = 1'b1; tick();
    drive_in(32'd0);           mdr_in = 1'b1; tick();
    read = 1'b1; mdr_in = 1'b1; tick();
    mdr_out = 1'b1; sample_bus("ram5_read", 32'hDEAD_BEEF);
    drive_in(32'h1234_5678);   mdr_in = 1'b1; tick();
    read = 1'b1; write = 1'b1; mdr_in = 1'b1; tick();
    mdr_out = 1'b1; sample_bus("rw_old_data", 32'hDEAD_BEEF);
    read = 1'b1; mdr_in = 1'b1; tick();
    mdr_out = 1'b1; sample_bus("rw_write_wins", 32'h1234_5678);
    drive_in(32'd0); mar_in = 1'b1; tick();
    read = 1'b1; mdr_in = 1'b1; tick();
    mdr_out = 1'b1; sample_bus("ram0_read", 32'hB080_0000);

    // asynchronous reset mid-run
    drive_in(32'h0080_0000); ir_in = 1'b1; tick();
    gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; tick();
    z_high_out = 1'b1; y_in = 1'b1; tick();
    inport_ext_input = 32'h0000_1234;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    expect_v(64'd0);
    observe("rst_outport", {32'd0, outport_ext_output});
    pc_out = 1'b1;     sample_bus("rst_pc", 32'd0);
    hi_out = 1'b1;     sample_bus("rst_hi", 32'd0);
    lo_out = 1'b1;     sample_bus("rst_lo", 32'd0);
    z_high_out = 1'b1; sample_bus("rst_zhi", 32'd0);
    z_low_out = 1'b1;  sample_bus("rst_zlo", 32'd0);
    mdr_out = 1'b1;    sample_bus("rst_mdr", 32'd0);
    inport_out = 1'b1; sample_bus("rst_in", 32'd0);
    c_out = 1'b1;      sample_bus("rst_ir_c", 32'd0);
    gra = 1'b1; r_out = 1'b1; sample_bus("rst_r0", 32'd0);
    sample_bus("rst_bus_idle", 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_in(32'h0080_0000); ir_in = 1'b1; tick();
    gra = 1'b1; r_out = 1'b1; sample_bus("rst_r1", 32'd0);
    drive_in(32'd1); alu_op = 4'd2; z_in = 1'b1; tick();
    z_low_out = 1'b1; sample_bus("rst_y_add", 32'd1);
    drive_in(32'd5); mar_in = 1'b1; tick();
    read = 1'b1; mdr_in = 1'b1; tick();
    mdr_out = 1'b1; sample_bus("ram_kept", 32'h1234_5678);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
